arbitrate: RTL

Round-robin N-to-1 stream arbiter that merges N independent valid/ready input streams into one tagged output stream. Each accepted word leaves as `{index, data}`, W+$clog2(N) bits wide, with the tag in the MSBs. It sits directly upstream of `multiplex`/`demultiplex` style consumers that expect a tagged stream. The output is registered, and the block sustains one word per cycle under continuous `m_ready`.

---
 rtl/arbitrate.sv | 76 +++++++
 1 files changed

// File: rtl/arbitrate.sv
// Round-robin N-to-1 stream arbiter: merges N valid/ready streams into one
// registered output stream tagged {index, data}.
module arbitrate #(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           s_valid,
    input  logic [N*W-1:0]         s_data,
    output logic [N-1:0]           s_ready,
    output logic                   m_valid,
    output logic [W+$clog2(N)-1:0] m_data,
    input  logic                   m_ready
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr;
    logic [IW-1:0] grant_idx;
    logic [IW:0]   scan;
    logic          found;
    logic          open;
    logic [W-1:0]  s_word [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign s_word[i] = s_data[i*W +: W];
    end

    // The output register can take a new word when empty or draining this cycle.
    assign open = !m_valid || m_ready;

    // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-two N works.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        found     = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int k = 0; k < N; k++) begin
            scan = {1'b0, ptr} + (IW+1)'(k);
            if (scan >= (IW+1)'(N)) begin
                scan = scan - (IW+1)'(N);
            end
            if (!found && s_valid[scan[IW-1:0]]) begin
                found     = 1'b1;
                grant_idx = scan[IW-1:0];
            end
        end
    end

    // Reset is folded in so no producer sees a grant during the reset cycle.
    always_comb begin
        s_ready = '0;
        if (rst && open && found) begin
            s_ready = N'(1) << grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            ptr     <= '0;
        end else if (open) begin
            if (found) begin
                m_valid <= 1'b1;
                m_data  <= {grant_idx, s_word[grant_idx]};
                ptr     <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
